ram_port_arbiter: RTL

- Shares the single-port program RAM (sync write, 1-cycle sync read) between two requesters: the CPU core (port C, default priority) and the host/debug readout path (port D).
- Sits between `risc`/debug serializer and the RAM instance at the chip top.
- One RAM access per cycle.
- Fixed CPU priority, with a starvation guard that forces a D grant after MAX_HOLD consecutive C grants while D waits.

---
 rtl/ram_port_arbiter.sv | 86 ++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-port arbiter for the single-port program RAM with a debug starvation guard
module ram_port_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [3:0]        hold_cnt_o
);

    localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

    logic [3:0]        hold_cnt;
    logic [ADDR_W-1:0] last_addr;
    logic              force_d;

    // Grants are gated by rst_n so nothing reaches the RAM while reset is held.
    always_comb begin
        force_d = dbg_req && (hold_cnt >= HOLD_LIMIT);
        dbg_gnt = rst_n && dbg_req && (!cpu_req || force_d);
        cpu_gnt = rst_n && cpu_req && !dbg_gnt;
    end

    // Only the granted port is selected, so X on an idle port never reaches mem_*.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = last_addr;
        mem_wdata = '0;
        if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end else if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt   <= 4'd0;
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
            last_addr  <= '0;
        end else begin
            cpu_rvalid <= cpu_gnt && !cpu_we;
            dbg_rvalid <= dbg_gnt && !dbg_we;
            if (cpu_gnt || dbg_gnt) begin
                last_addr <= mem_addr;
            end
            // The guard only counts C wins while D is left waiting.
            if (cpu_gnt && dbg_req) begin
                if (hold_cnt != 4'hf) begin
                    hold_cnt <= hold_cnt + 4'd1;
                end
            end else if (dbg_gnt || !dbg_req) begin
                hold_cnt <= 4'd0;
            end
        end
    end

    assign cpu_rdata  = mem_rdata;
    assign dbg_rdata  = mem_rdata;
    assign hold_cnt_o = hold_cnt;

endmodule
